// File: rtl/spi_pkg.sv
// Shared definitions for the SPI FIFO transmitter.
// Contents: FSM state encoding, default parameter values, mode-0 clock
// polarity/phase constants and a counter-width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        SHIFT,
        GAP
    } state_e;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned DEF_GAP_CYC = 4;

    // SPI mode 0: sclk idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Width of a counter that must hold 0..n-1, never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// sclk generator: counts CLK_DIV clk cycles per sclk half-period.
// Ports:
//   clk, rst   clock, async active-low reset
//   clr_i      forces counter to 0 and sclk to its idle level
//   en_i       advances the half-period counter
//   sclk_o     registered SPI clock
//   rise_c_o   combinational: sclk goes high on the next clk edge
//   fall_c_o   combinational: sclk goes low on the next clk edge
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_c_o,
    output logic fall_c_o
);

    localparam int unsigned CNT_W = cnt_w(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             half_end_c;

    assign half_end_c = en_i && !clr_i && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign rise_c_o   = half_end_c && !sclk_q;
    assign fall_c_o   = half_end_c &&  sclk_q;
    assign sclk_o     = sclk_q;

    // Half-period counter; sclk toggles when a half-period completes.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (clr_i) begin
            cnt_d  = '0;
            sclk_d = SPI_CPOL;
        end else if (half_end_c) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else if (en_i) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_fifo_tx.sv
// SPI mode-0 transmitter draining a byte FIFO, MSB first, one byte per frame.
// Optional macro SPI_BURST_EN: back-to-back bytes share one cs_n-low window
// while the FIFO has data and enable stays high.
// Ports:
//   clk, rst      clock, async active-low reset
//   enable        permits new frames (sampled in IDLE and at byte end)
//   fifo_empty    FIFO empty flag
//   fifo_rd       one-cycle FIFO pop strobe
//   fifo_data     FIFO read data, valid one cycle after fifo_rd
//   sclk, mosi    SPI clock / data out
//   cs_n          SPI chip select, active-low
//   busy          high whenever the FSM is not idle
//   byte_done     one-cycle pulse after the last bit of each byte
module spi_fifo_tx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              byte_done
);

    localparam int unsigned BIT_W = cnt_w(DATA_W);
    localparam int unsigned GAP_W = cnt_w(GAP_CYC);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              byte_done_q, byte_done_d;
    logic              div_clr_c, div_en_c, rise_c, fall_c;
    logic              burst_go_c;

    assign div_en_c  = (state_q == SHIFT);
    assign div_clr_c = !div_en_c;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (div_clr_c),
        .en_i     (div_en_c),
        .sclk_o   (sclk),
        .rise_c_o (rise_c),
        .fall_c_o (fall_c)
    );

    // Whether the byte that is finishing chains straight into the next pop.
`ifdef SPI_BURST_EN
    assign burst_go_c = enable && !fifo_empty;
`else
    assign burst_go_c = 1'b0;
`endif

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        fifo_rd_d   = 1'b0;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        byte_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                if (enable && !fifo_empty) begin
                    fifo_rd_d = 1'b1;
                    state_d   = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_data;
                mosi_d  = fifo_data[DATA_W-1];
                cs_n_d  = 1'b0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Shift after the slave has sampled; present the new MSB on the fall.
                if (rise_c) begin
                    shift_d = shift_q << 1;
                end
                if (fall_c) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        byte_done_d = 1'b1;
                        mosi_d      = 1'b0;
                        if (burst_go_c) begin
                            fifo_rd_d = 1'b1;
                            state_d   = POP;
                        end else begin
                            cs_n_d  = 1'b1;
                            gap_d   = '0;
                            state_d = GAP;
                        end
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        mosi_d = shift_q[DATA_W-1];
                    end
                end
            end
            GAP: begin
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            fifo_rd_q   <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            gap_q       <= gap_d;
            fifo_rd_q   <= fifo_rd_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign fifo_rd   = fifo_rd_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign busy      = busy_q;
    assign byte_done = byte_done_q;

endmodule

// File: tb/tb_spi_fifo_tx.sv
// Testbench for spi_fifo_tx: FIFO model feeds the DUT, popped bytes go to an
// expected queue, and a monitor acting as an SPI slave checks each byte and
// the frame timing against it.
module tb_spi_fifo_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned CD = 2;
    localparam int unsigned GC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_rd, sclk, mosi, cs_n, busy, byte_done;

    always #5 clk = ~clk;

    spi_fifo_tx #(
        .DATA_W  (DW),
        .CLK_DIV (CD),
        .GAP_CYC (GC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: data appears after the pop strobe; flags settle mid-cycle.
    always @(negedge clk) begin
        if (rst && fifo_rd) begin
            if (fifo_q.size() == 0) begin
                chk("pop_underflow", 1, 0);
            end else begin
                fifo_data = fifo_q.pop_front();
                exp_q.push_back(fifo_data);
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    end

    // Monitor / SPI slave state.
    int            cyc = 0;
    int            pops = 0, frames = 0, bytes = 0;
    int            last_pop = -1000, first_rise = 0, last_bd = -1;
    int            rises_b = 0, rises_w = 0;
    logic [DW-1:0] rx = '0;
    logic          prev_sclk = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            rises_b   = 0;
            rises_w   = 0;
            last_bd   = -1;
            prev_sclk = 1'b0;
            prev_cs   = 1'b1;
            prev_busy = 1'b0;
        end else begin
            if (fifo_rd) begin
                pops++;
                last_pop = cyc;
                chk("rd_when_empty", int'(fifo_empty), 0);
            end
            if (sclk && !prev_sclk) begin
                if (rises_b == 0) begin
                    chk("rd_to_first_rise", cyc - last_pop, 2 + CD);
                    first_rise = cyc;
                end
                rx = {rx[DW-2:0], mosi};
                rises_b++;
                rises_w++;
            end
            if (cs_n != prev_cs) begin
                chk("cs_toggle_sclk_high", int'(sclk), 0);
                if (!cs_n) begin
                    frames++;
                    rises_w = 0;
                    chk("rd_to_cs_low", cyc - last_pop, 2);
                end else begin
`ifdef SPI_BURST_EN
                    chk("rises_per_window", rises_w % DW, 0);
`else
                    chk("rises_per_frame", rises_w, DW);
`endif
                end
            end
            if (byte_done) begin
                chk("rises_per_byte", rises_b, DW);
                chk("shift_len", cyc - first_rise, CD * (2 * DW - 1));
                if (exp_q.size() == 0) chk("byte_unexpected", 1, 0);
                else chk("byte_data", int'(rx), int'(exp_q.pop_front()));
                rises_b = 0;
                last_bd = cyc;
                bytes++;
            end
            if (!busy && prev_busy && last_bd >= 0) begin
                chk("gap_len", cyc - last_bd, GC);
            end
            prev_sclk = sclk;
            prev_cs   = cs_n;
            prev_busy = busy;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cs_n"}, int'(cs_n), 1);
        chk({tag, "_sclk"}, int'(sclk), 0);
        chk({tag, "_mosi"}, int'(mosi), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fifo_rd"}, int'(fifo_rd), 0);
        chk({tag, "_byte_done"}, int'(byte_done), 0);
    endtask

    // Wait until idle with nothing left to send (or sending disallowed).
    task automatic wait_idle(input int max_cyc);
        int done = 0;
        for (int i = 0; i < max_cyc && done == 0; i++) begin
            @(posedge clk);
            #2;
            if (!busy && (fifo_q.size() == 0 || !enable)) done = 1;
        end
        if (done == 0) chk("wait_idle_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rises(input int n, input int max_cyc);
        int done = 0;
        for (int i = 0; i < max_cyc && done == 0; i++) begin
            @(posedge clk);
            #2;
            if (rises_b >= n) done = 1;
        end
        if (done == 0) chk("wait_rises_timeout", 0, 1);
    endtask

    logic [DW-1:0] eight[8];
    int p0, b0, f0, n;

    initial begin
        eight = '{8'h02, 8'h04, 8'h08, 8'h16, 8'h32, 8'h64, 8'h6f, 8'hff};
        rst    = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Empty FIFO with enable held: no pops.
        enable = 1'b1;
        p0 = pops;
        repeat (100) @(posedge clk);
        #2;
        chk("empty_no_rd", pops - p0, 0);
        chk("empty_busy", int'(busy), 0);

        // Single byte.
        @(posedge clk);
        p0 = pops; b0 = bytes; f0 = frames;
        fifo_q.push_back(8'h02);
        wait_idle(300);
        chk("single_pops", pops - p0, 1);
        chk("single_bytes", bytes - b0, 1);
        chk("single_frames", frames - f0, 1);

        // Eight preloaded bytes.
        @(posedge clk);
        p0 = pops; b0 = bytes; f0 = frames;
        enable = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(eight[i]);
        repeat (2) @(posedge clk);
        enable = 1'b1;
        wait_idle(3000);
        chk("eight_pops", pops - p0, 8);
        chk("eight_bytes", bytes - b0, 8);
`ifdef SPI_BURST_EN
        chk("eight_frames", frames - f0, 1);
`else
        chk("eight_frames", frames - f0, 8);
`endif

        // enable dropped during bit 3 of 8'hff.
        @(posedge clk);
        p0 = pops; b0 = bytes;
        fifo_q.push_back(8'hff);
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h33);
        wait_rises(3, 500);
        enable = 1'b0;
        wait_idle(500);
        repeat (30) @(posedge clk);
        #2;
        chk("drop_pops", pops - p0, 1);
        chk("drop_bytes", bytes - b0, 1);
        chk("drop_left", fifo_q.size(), 2);
        chk("drop_busy", int'(busy), 0);
        fifo_q.delete();
        repeat (2) @(posedge clk);

        // Randomized batches.
        for (int r = 0; r < 6; r++) begin
            @(posedge clk);
            p0 = pops; b0 = bytes;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) fifo_q.push_back(DW'($urandom));
            enable = 1'b1;
            wait_idle(2000);
            chk("rand_pops", pops - p0, n);
            chk("rand_bytes", bytes - b0, n);
        end

        // Asynchronous reset mid-SHIFT, then idle with empty FIFO.
        @(posedge clk);
        fifo_q.push_back(8'ha5);
        fifo_q.push_back(8'h3c);
        wait_rises(4, 500);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        fifo_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        p0 = pops;
        repeat (20) @(posedge clk);
        #2;
        chk("post_reset_pops", pops - p0, 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_cs_n", int'(cs_n), 1);

        enable = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
